// File: rtl/prf_multiport_if.sv
// Bus bundle between the physical register file and its writeback, dispatch and issue clients.
// The register file takes the slave modport; the driving pipeline takes master.
interface prf_multiport_if #(
    parameter int NUM_PREGS = 64,
    parameter int XLEN      = 32,
    parameter int NUM_WR    = 7,
    parameter int NUM_RD    = 6,
    parameter int NUM_ALLOC = 3,
    parameter int IDXW      = $clog2(NUM_PREGS)
);
    logic [NUM_WR-1:0]                 wr_en;
    logic [NUM_WR-1:0][IDXW-1:0]       wr_idx;
    logic [NUM_WR-1:0][XLEN-1:0]       wr_data;
    logic [NUM_ALLOC-1:0]              alloc_en;
    logic [NUM_ALLOC-1:0][IDXW-1:0]    alloc_idx;
    logic [NUM_RD-1:0][IDXW-1:0]       rd_idx;
    logic [NUM_RD-1:0][XLEN-1:0]       rd_data;
    logic [NUM_RD-1:0]                 rd_ready;
    logic [NUM_PREGS-1:0]              ready_vec;
    logic                              write_conflict;
    logic [NUM_PREGS-1:0][XLEN-1:0]    physical_register;

    modport master (
        output wr_en, wr_idx, wr_data, alloc_en, alloc_idx, rd_idx,
        input  rd_data, rd_ready, ready_vec, write_conflict, physical_register
    );

    modport slave (
        input  wr_en, wr_idx, wr_data, alloc_en, alloc_idx, rd_idx,
        output rd_data, rd_ready, ready_vec, write_conflict, physical_register
    );
endinterface

// File: rtl/prf_multiport.sv
// Parametrised physical register file with per-register ready scoreboard and sticky write-conflict flag.
// Writes/allocs land at the posedge; reads are 0-cycle combinational; no backpressure (always accepts).
module prf_multiport #(
    parameter int NUM_PREGS = 64,
    parameter int XLEN      = 32,
    parameter int NUM_WR    = 7,
    parameter int NUM_RD    = 6,
    parameter int NUM_ALLOC = 3,
    parameter bit BYPASS    = 1'b1,
    parameter int IDXW      = $clog2(NUM_PREGS)
) (
    input  logic            clock,
    input  logic            reset,
    prf_multiport_if.slave  bus
);
    logic [NUM_PREGS-1:0][XLEN-1:0] val_q, val_d;
    logic [NUM_PREGS-1:0]           rdy_q, rdy_d;
    logic                           conflict_q, conflict_d;
    logic [NUM_RD-1:0][XLEN-1:0]    rd_data_c;
    logic [NUM_RD-1:0]              rd_ready_c;

    // Later ports overwrite earlier ones, so the highest-numbered port wins;
    // allocs are applied after writes so a same-cycle alloc leaves ready cleared.
    always_comb begin
        val_d      = val_q;
        rdy_d      = rdy_q;
        conflict_d = conflict_q;
        for (int i = 0; i < NUM_WR; i++) begin
            if (bus.wr_en[i] && (bus.wr_idx[i] != '0)) begin
                val_d[bus.wr_idx[i]] = bus.wr_data[i];
                rdy_d[bus.wr_idx[i]] = 1'b1;
            end
        end
        for (int j = 0; j < NUM_ALLOC; j++) begin
            if (bus.alloc_en[j] && (bus.alloc_idx[j] != '0)) begin
                rdy_d[bus.alloc_idx[j]] = 1'b0;
            end
        end
        for (int i = 0; i < NUM_WR; i++) begin
            for (int k = i + 1; k < NUM_WR; k++) begin
                if (bus.wr_en[i] && bus.wr_en[k] && (bus.wr_idx[i] == bus.wr_idx[k])
                    && (bus.wr_idx[i] != '0)) begin
                    conflict_d = 1'b1;
                end
            end
        end
        val_d[0] = '0;
        rdy_d[0] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            val_q      <= '0;
            rdy_q      <= '1;
            conflict_q <= 1'b0;
        end else begin
            val_q      <= val_d;
            rdy_q      <= rdy_d;
            conflict_q <= conflict_d;
        end
    end

    // Preg 0 never matches a write (nonzero-index gate), so it always reads the hardwired zero.
    always_comb begin
        rd_data_c  = '0;
        rd_ready_c = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            rd_data_c[r]  = val_q[bus.rd_idx[r]];
            rd_ready_c[r] = rdy_q[bus.rd_idx[r]];
            if (BYPASS) begin
                for (int i = 0; i < NUM_WR; i++) begin
                    if (bus.wr_en[i] && (bus.wr_idx[i] != '0) && (bus.wr_idx[i] == bus.rd_idx[r])) begin
                        rd_data_c[r]  = bus.wr_data[i];
                        rd_ready_c[r] = 1'b1;
                    end
                end
            end
        end
    end

    assign bus.rd_data           = rd_data_c;
    assign bus.rd_ready          = rd_ready_c;
    assign bus.ready_vec         = rdy_q;
    assign bus.write_conflict    = conflict_q;
    assign bus.physical_register = val_q;
endmodule

// File: tb/tb_prf_multiport.sv
// Self-checking bench: directed cases on the default PRF, then random traffic on it and on a
// 32-entry, 4-write, non-bypassed variant against a reference model.
module tb_prf_multiport;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    prf_multiport_if ifa ();
    prf_multiport_if #(.NUM_PREGS(32), .NUM_WR(4)) ifb ();

    prf_multiport u_dut_a (.clock(clock), .reset(reset), .bus(ifa.slave));
    prf_multiport #(.NUM_PREGS(32), .NUM_WR(4), .BYPASS(1'b0)) u_dut_b (
        .clock(clock), .reset(reset), .bus(ifb.slave));

    int checks = 0;
    int errors = 0;

    logic [31:0] mval [2][64];
    logic        mrdy [2][64];
    logic        mconf [2];

    logic        w_en  [2][7];
    int          w_idx [2][7];
    logic [31:0] w_dat [2][7];
    logic        a_en  [2][3];
    int          a_idx [2][3];
    int          r_idx [2][6];

    logic [32:0] sbq [$];
    logic [32:0] exp_e, got_e;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int nwr_of(input int k);
        return (k == 0) ? 7 : 4;
    endfunction

    function automatic int np_of(input int k);
        return (k == 0) ? 64 : 32;
    endfunction

    task automatic idle_all();
        ifa.wr_en = '0; ifa.wr_idx = '0; ifa.wr_data = '0;
        ifa.alloc_en = '0; ifa.alloc_idx = '0; ifa.rd_idx = '0;
        ifb.wr_en = '0; ifb.wr_idx = '0; ifb.wr_data = '0;
        ifb.alloc_en = '0; ifb.alloc_idx = '0; ifb.rd_idx = '0;
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
        idle_all();
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 64; p++) begin
                mval[k][p] = '0;
                mrdy[k][p] = 1'b1;
            end
            mconf[k] = 1'b0;
        end
    endtask

    // Expected {ready, data} for a read of idx on instance k in the current cycle.
    function automatic logic [32:0] exp_read(input int k, input int idx);
        logic [31:0] d;
        logic        rr;
        d  = mval[k][idx];
        rr = mrdy[k][idx];
        if (k == 0 && idx != 0) begin
            for (int i = 0; i < 7; i++) begin
                if (w_en[k][i] && w_idx[k][i] == idx) begin
                    d  = w_dat[k][i];
                    rr = 1'b1;
                end
            end
        end
        return {rr, d};
    endfunction

    task automatic model_step(input int k);
        for (int i = 0; i < nwr_of(k); i++)
            for (int m = i + 1; m < nwr_of(k); m++)
                if (w_en[k][i] && w_en[k][m] && w_idx[k][i] == w_idx[k][m] && w_idx[k][i] != 0)
                    mconf[k] = 1'b1;
        for (int i = 0; i < nwr_of(k); i++)
            if (w_en[k][i] && w_idx[k][i] != 0) begin
                mval[k][w_idx[k][i]] = w_dat[k][i];
                mrdy[k][w_idx[k][i]] = 1'b1;
            end
        for (int j = 0; j < 3; j++)
            if (a_en[k][j] && a_idx[k][j] != 0)
                mrdy[k][a_idx[k][j]] = 1'b0;
    endtask

    initial begin
        idle_all();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        for (int p = 0; p < 64; p++) chk("rst_val", ifa.physical_register[p], 0);
        chk("rst_ready_vec", ifa.ready_vec, {64{1'b1}});
        chk("rst_conflict", ifa.write_conflict, 0);

        // Writes to preg 0 are dropped and reads of preg 0 never bypass.
        cyc();
        reset = 1'b1;
        ifa.wr_en[1] = 1'b1; ifa.wr_idx[1] = 6'd0; ifa.wr_data[1] = 32'd100;
        ifa.rd_idx[0] = 6'd0;
        @(negedge clock);
        chk("p0_rd_data", ifa.rd_data[0], 0);
        chk("p0_rd_ready", ifa.rd_ready[0], 1);
        cyc();
        @(negedge clock);
        chk("p0_val", ifa.physical_register[0], 0);

        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 7; i++) begin
                cyc();
                ifa.wr_en[i]   = 1'b1;
                ifa.wr_idx[i]  = 6'((pass == 0 ? 1 : 8) + i);
                ifa.wr_data[i] = 32'((pass == 0 ? 1 : 8) + i);
                cyc();
                @(negedge clock);
                chk("port_val", ifa.physical_register[(pass == 0 ? 1 : 8) + i], (pass == 0 ? 1 : 8) + i);
                chk("port_rdy", ifa.ready_vec[(pass == 0 ? 1 : 8) + i], 1);
            end
        end

        cyc();
        ifa.alloc_en[0] = 1'b1; ifa.alloc_idx[0] = 6'd20;
        cyc();
        ifa.wr_en[0] = 1'b1; ifa.wr_idx[0] = 6'd20; ifa.wr_data[0] = 32'hDEADBEEF;
        ifa.rd_idx[0] = 6'd20;
        @(negedge clock);
        chk("alloc_clear", ifa.ready_vec[20], 0);
        chk("byp_data", ifa.rd_data[0], 32'hDEADBEEF);
        chk("byp_ready", ifa.rd_ready[0], 1);
        cyc();
        @(negedge clock);
        chk("wb_ready", ifa.ready_vec[20], 1);
        chk("wb_val", ifa.physical_register[20], 32'hDEADBEEF);

        cyc();
        ifa.alloc_en[1] = 1'b1; ifa.alloc_idx[1] = 6'd30;
        ifa.wr_en[3] = 1'b1; ifa.wr_idx[3] = 6'd30; ifa.wr_data[3] = 32'd5;
        cyc();
        @(negedge clock);
        chk("aw_val", ifa.physical_register[30], 5);
        chk("aw_rdy", ifa.ready_vec[30], 0);

        // Colliding writes to preg 0 must not raise the conflict flag.
        cyc();
        ifa.wr_en[0] = 1'b1; ifa.wr_en[6] = 1'b1;
        ifa.wr_data[0] = 32'd7; ifa.wr_data[6] = 32'd9;
        cyc();
        @(negedge clock);
        chk("p0_noconf", ifa.write_conflict, 0);

        cyc();
        ifa.wr_en[2] = 1'b1; ifa.wr_idx[2] = 6'd40; ifa.wr_data[2] = 32'd111;
        ifa.wr_en[5] = 1'b1; ifa.wr_idx[5] = 6'd40; ifa.wr_data[5] = 32'd222;
        cyc();
        @(negedge clock);
        chk("conf_val", ifa.physical_register[40], 222);
        chk("conf_set", ifa.write_conflict, 1);
        repeat (5) cyc();
        @(negedge clock);
        chk("conf_sticky", ifa.write_conflict, 1);
        cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        @(negedge clock);
        chk("conf_clr", ifa.write_conflict, 0);
        chk("clr_val", ifa.physical_register[40], 0);
        chk("clr_ready_vec", ifa.ready_vec, {64{1'b1}});

        model_reset();
        for (int c = 0; c < 200; c++) begin
            cyc();
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 7; i++) begin
                    w_en[k][i]  = (i < nwr_of(k)) && ($urandom_range(0, 99) < 60);
                    w_idx[k][i] = (c % 2 == 0) ? $urandom_range(0, 15) : $urandom_range(0, np_of(k) - 1);
                    w_dat[k][i] = $urandom;
                end
                for (int j = 0; j < 3; j++) begin
                    a_en[k][j]  = ($urandom_range(0, 99) < 40);
                    a_idx[k][j] = (c % 2 == 0) ? $urandom_range(0, 15) : $urandom_range(0, np_of(k) - 1);
                end
                for (int r = 0; r < 6; r++)
                    r_idx[k][r] = ($urandom_range(0, 1) == 1) ? (r < 3 ? a_idx[k][r] : w_idx[k][r])
                                                                : $urandom_range(0, np_of(k) - 1);
            end
            for (int i = 0; i < 7; i++) begin
                ifa.wr_en[i] = w_en[0][i]; ifa.wr_idx[i] = 6'(w_idx[0][i]); ifa.wr_data[i] = w_dat[0][i];
            end
            for (int i = 0; i < 4; i++) begin
                ifb.wr_en[i] = w_en[1][i]; ifb.wr_idx[i] = 5'(w_idx[1][i]); ifb.wr_data[i] = w_dat[1][i];
            end
            for (int j = 0; j < 3; j++) begin
                ifa.alloc_en[j] = a_en[0][j]; ifa.alloc_idx[j] = 6'(a_idx[0][j]);
                ifb.alloc_en[j] = a_en[1][j]; ifb.alloc_idx[j] = 5'(a_idx[1][j]);
            end
            for (int r = 0; r < 6; r++) begin
                ifa.rd_idx[r] = 6'(r_idx[0][r]);
                ifb.rd_idx[r] = 5'(r_idx[1][r]);
            end
            for (int k = 0; k < 2; k++)
                for (int r = 0; r < 6; r++) sbq.push_back(exp_read(k, r_idx[k][r]));

            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                for (int r = 0; r < 6; r++) begin
                    exp_e = sbq.pop_front();
                    if (k == 0) got_e = {ifa.rd_ready[r], ifa.rd_data[r]};
                    else        got_e = {ifb.rd_ready[r], ifb.rd_data[r]};
                    chk(k == 0 ? "rnd_rd_a" : "rnd_rd_b", got_e, exp_e);
                end
                for (int p = 0; p < np_of(k); p++) begin
                    if (k == 0) begin
                        chk("rnd_val_a", ifa.physical_register[p], mval[0][p]);
                        chk("rnd_rdy_a", ifa.ready_vec[p], mrdy[0][p]);
                    end else begin
                        chk("rnd_val_b", ifb.physical_register[p], mval[1][p]);
                        chk("rnd_rdy_b", ifb.ready_vec[p], mrdy[1][p]);
                    end
                end
                chk(k == 0 ? "rnd_conf_a" : "rnd_conf_b",
                    k == 0 ? ifa.write_conflict : ifb.write_conflict, mconf[k]);
                model_step(k);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
